// File: rtl/run_merge8_if.sv
// run_merge8_if
//   Output stream of the run merger: one merged word per accepted beat.
//   master : producer side (run_merge8) drives out_valid/out_data/out_last,
//            samples out_ready.
//   slave  : consumer side, drives out_ready.
//   A beat is accepted on a rising clock edge with out_valid && out_ready.
interface run_merge8_if #(
   parameter int unsigned WIDTH = 32
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/run_merge8.sv
// run_merge8
//   Merge step of the TimSort flow. Captures two ascending runs of RUN_LEN
//   words (one pass of the insertion sorter each) and streams them out as a
//   single ascending sequence of 2*RUN_LEN words over a valid/ready handshake.
//   Ties are taken from run A first, so the merge is stable. The compare is
//   unsigned.
//
// Parameters
//   WIDTH    data word width in bits
//   RUN_LEN  words per input run (>= 2)
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     capture run_a/run_b and begin a merge (honoured only in IDLE)
//   run_a     sorted run A, word k at [k*WIDTH +: WIDTH], word 0 smallest
//   run_b     sorted run B, same packing
//   busy      high from the capture cycle until the done cycle
//   done      one-cycle pulse after the final beat
//   sort_err  an input run was not non-decreasing (order-check build only)
//   out_if    output stream (out_valid, out_ready, out_data, out_last)
//
// Build option
//   RUN_MERGE_ORDER_CHECK_EN  when defined, both runs are checked for
//   non-decreasing order at capture; sort_err is set in the first MERGE
//   cycle and held until the next accepted start. When undefined, sort_err
//   is tied low and no check logic exists.
module run_merge8 #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned RUN_LEN = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [WIDTH*RUN_LEN-1:0] run_a,
   input  logic [WIDTH*RUN_LEN-1:0] run_b,
   output logic                     busy,
   output logic                     done,
   output logic                     sort_err,
   run_merge8_if.master             out_if
);

   localparam int unsigned IW = $clog2(RUN_LEN);
   localparam int unsigned PW = IW + 1;
   localparam int unsigned CW = $clog2(2 * RUN_LEN) + 1;

   localparam logic [PW-1:0] PTR_END  = PW'(RUN_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * RUN_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MERGE = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    ia_q, ia_d;
   logic [PW-1:0]    ib_q, ib_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] mem_a_q [RUN_LEN];
   logic [WIDTH-1:0] mem_a_d [RUN_LEN];
   logic [WIDTH-1:0] mem_b_q [RUN_LEN];
   logic [WIDTH-1:0] mem_b_d [RUN_LEN];

   logic             a_left;
   logic             b_left;
   logic [IW-1:0]    ia_idx;
   logic [IW-1:0]    ib_idx;
   logic [WIDTH-1:0] word_a;
   logic [WIDTH-1:0] word_b;
   logic             sel_a;
   logic             merging;
   logic             last_word;
   logic             beat;
   logic             capture;

   // ---------------------------------------------------------------------
   // Head-of-run selection, decoded from registered state only so that
   // out_data/out_last cannot change while a beat is stalled.
   // ---------------------------------------------------------------------
   always_comb begin
      a_left = (ia_q < PTR_END);
      b_left = (ib_q < PTR_END);
      // An exhausted pointer equals RUN_LEN, which is not a valid index;
      // park it on entry 0 (its word is then ignored by sel_a).
      ia_idx = a_left ? ia_q[IW-1:0] : '0;
      ib_idx = b_left ? ib_q[IW-1:0] : '0;
      word_a = mem_a_q[ia_idx];
      word_b = mem_b_q[ib_idx];
      // Ties go to A to keep the merge stable.
      sel_a  = !b_left || (a_left && (word_a <= word_b));
   end

   always_comb begin
      merging   = (state_q == MERGE);
      last_word = merging && (cnt_q == CNT_LAST);
      beat      = merging && out_if.out_ready;
   end

   assign out_if.out_valid = merging;
   assign out_if.out_data  = sel_a ? word_a : word_b;
   assign out_if.out_last  = last_word;
   assign busy             = busy_q;
   assign done             = (state_q == DONE);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ia_d    = ia_q;
      ib_d    = ib_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      capture = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               ia_d    = '0;
               ib_d    = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = MERGE;
            end
         end

         MERGE: begin
            if (beat) begin
               if (sel_a) begin
                  ia_d = ia_q + PW'(1);
               end else begin
                  ib_d = ib_q + PW'(1);
               end
               cnt_d = cnt_q + CW'(1);
               if (last_word) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ia_q    <= '0;
         ib_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ia_q    <= ia_d;
         ib_q    <= ib_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // ---------------------------------------------------------------------
   // Run storage: loaded on capture only, deliberately not reset.
   // ---------------------------------------------------------------------
   always_comb begin
      for (int unsigned k = 0; k < RUN_LEN; k++) begin
         mem_a_d[k] = capture ? run_a[k*WIDTH +: WIDTH] : mem_a_q[k];
         mem_b_d[k] = capture ? run_b[k*WIDTH +: WIDTH] : mem_b_q[k];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < RUN_LEN; k++) begin
         mem_a_q[k] <= mem_a_d[k];
         mem_b_q[k] <= mem_b_d[k];
      end
   end

   // ---------------------------------------------------------------------
   // Optional input order check, evaluated on the raw inputs at capture so
   // the flag is visible in the first MERGE cycle.
   // ---------------------------------------------------------------------
`ifdef RUN_MERGE_ORDER_CHECK_EN
   logic sort_err_q, sort_err_d;
   logic run_unsorted;

   always_comb begin
      run_unsorted = 1'b0;
      for (int unsigned k = 0; k < RUN_LEN - 1; k++) begin
         if ((run_a[k*WIDTH +: WIDTH] > run_a[(k+1)*WIDTH +: WIDTH]) ||
             (run_b[k*WIDTH +: WIDTH] > run_b[(k+1)*WIDTH +: WIDTH])) begin
            run_unsorted = 1'b1;
         end
      end
      sort_err_d = capture ? run_unsorted : sort_err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sort_err_q <= 1'b0;
      end else begin
         sort_err_q <= sort_err_d;
      end
   end

   assign sort_err = sort_err_q;
`else
   assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_run_merge8.sv
// tb_run_merge8
//   Directed bench for run_merge8 (WIDTH=32, RUN_LEN=8). Each stimulus
//   pushes its hand-computed merged sequence (word, last flag, source run)
//   into a queue; an independent monitor pops and compares on every
//   accepted beat and checks stall stability.
module tb_run_merge8;

   localparam int unsigned W = 32;
   localparam int unsigned L = 8;

   typedef struct packed {
      logic         src;
      logic         last;
      logic [W-1:0] data;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W*L-1:0] run_a;
   logic [W*L-1:0] run_b;
   logic           busy;
   logic           done;
   logic           sort_err;

   run_merge8_if #(.WIDTH(W)) bus ();

   run_merge8 #(
      .WIDTH   (W),
      .RUN_LEN (L)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .run_a    (run_a),
      .run_b    (run_b),
      .busy     (busy),
      .done     (done),
      .sort_err (sort_err),
      .out_if   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int beats    = 0;

   exp_t         exp_q[$];
   logic [W-1:0] va [L];
   logic [W-1:0] vb [L];
   logic [W-1:0] ve [2*L];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Monitor: pops on accepted beats, checks hold during stalls.
   // ------------------------------------------------------------------
   bit           stalled = 1'b0;
   logic [W-1:0] held_data;
   logic         held_last;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n || !bus.out_valid) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("stall_data", bus.out_data, held_data);
            chk("stall_last", bus.out_last, held_last);
         end
         if (!bus.out_ready) begin
            stalled   = 1'b1;
            held_data = bus.out_data;
            held_last = bus.out_last;
         end else begin
            stalled = 1'b0;
            chk("beat_expected", exp_q.size() == 0, 0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_data", bus.out_data, e.data);
               chk("out_last", bus.out_last, e.last);
               chk("src_run_a", dut.sel_a, e.src);
            end
            beats++;
         end
      end
   end

   // ------------------------------------------------------------------
   // One complete merge of va/vb, expected sequence ve/exp_src.
   // ------------------------------------------------------------------
   task automatic run_test(input logic [15:0] exp_src, input bit bp, input bit exp_err);
      int cyc;
      int stall_cnt;
      int r;
      bit got_done;
      exp_t e;
      for (int k = 0; k < 2*L; k++) begin
         e.src  = exp_src[k];
         e.last = (k == 2*L-1);
         e.data = ve[k];
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      for (int k = 0; k < L; k++) begin
         run_a[k*W +: W] = va[k];
         run_b[k*W +: W] = vb[k];
      end
      start         = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("latency_valid", bus.out_valid, 1);
      chk("busy_merge", busy, 1);
      chk("sort_err_first", sort_err, exp_err);
      cyc       = 1;
      stall_cnt = 0;
      got_done  = 1'b0;
      while (cyc < 2000) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (bp) begin
            // garbage runs plus start pulses must not disturb the merge
            run_a = {L{32'hDEAD_BEEF}};
            run_b = '0;
            start = ($urandom_range(0, 4) == 0);
            if (stall_cnt > 0) begin
               bus.out_ready = 1'b0;
               stall_cnt--;
            end else begin
               r = $urandom_range(0, 9);
               if (r == 0) begin
                  stall_cnt     = 7;
                  bus.out_ready = 1'b0;
               end else begin
                  bus.out_ready = (r > 3);
               end
            end
         end
         @(negedge clk);
         cyc++;
      end
      start         = 1'b0;
      bus.out_ready = 1'b1;
      chk("done_seen", got_done, 1);
      if (!bp) chk("done_cycle", cyc, 2*L+1);
      chk("valid_in_done", bus.out_valid, 0);
      chk("queue_drained", exp_q.size(), 0);
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("done_pulse_len", done, 0);
      chk("valid_after", bus.out_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      run_a         = '0;
      run_b         = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_last", bus.out_last, 0);
      chk("rst_sort_err", sort_err, 0);
      rst_n = 1'b1;

      // interleaved runs
      va = '{1, 3, 5, 7, 9, 11, 13, 15};
      vb = '{2, 4, 6, 8, 10, 12, 14, 16};
      ve = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
      run_test(16'h5555, 1'b0, 1'b0);

      // disjoint: all of B first, A pointer parked at 0
      va = '{100, 101, 102, 103, 104, 105, 106, 107};
      vb = '{0, 1, 2, 3, 4, 5, 6, 7};
      ve = '{0, 1, 2, 3, 4, 5, 6, 7, 100, 101, 102, 103, 104, 105, 106, 107};
      run_test(16'hFF00, 1'b0, 1'b0);

      // ties: every A word before any B word
      va = '{5, 5, 5, 5, 5, 5, 5, 5};
      vb = '{5, 5, 5, 5, 5, 5, 5, 5};
      ve = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
      run_test(16'h00FF, 1'b0, 1'b0);

      // unsigned compare: all-ones word comes out last
      va = '{0, 1, 2, 3, 4, 5, 6, 32'hFFFF_FFFF};
      vb = '{10, 20, 30, 40, 50, 60, 70, 80};
      ve = '{0, 1, 2, 3, 4, 5, 6, 10, 20, 30, 40, 50, 60, 70, 80, 32'hFFFF_FFFF};
      run_test(16'h807F, 1'b0, 1'b0);

      // random backpressure with ties across runs and stray starts
      va = '{2, 2, 7, 30, 31, 50, 60, 90};
      vb = '{1, 2, 8, 9, 40, 50, 61, 100};
      ve = '{1, 2, 2, 2, 7, 8, 9, 30, 31, 40, 50, 50, 60, 61, 90, 100};
      run_test(16'h5596, 1'b1, 1'b0);

      // reset after the fifth beat
      begin
         exp_t e;
         int   cyc;
         for (int k = 0; k < 5; k++) begin
            e.src  = (k % 2 == 0);
            e.last = 1'b0;
            e.data = W'(k + 1);
            exp_q.push_back(e);
         end
         beats = 0;
         @(posedge clk); #1;
         for (int k = 0; k < L; k++) begin
            run_a[k*W +: W] = W'(2*k + 1);
            run_b[k*W +: W] = W'(2*k + 2);
         end
         start         = 1'b1;
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         cyc   = 0;
         while (beats < 5 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("reset_beats", beats, 5);
         #1;
         rst_n = 1'b0;
         #1;
         chk("async_valid", bus.out_valid, 0);
         chk("async_busy", busy, 0);
         chk("async_done", done, 0);
         chk("async_last", bus.out_last, 0);
         chk("reset_queue", exp_q.size(), 0);
         exp_q.delete();
         repeat (2) @(posedge clk);
         #2;
         rst_n = 1'b1;
      end

      // fresh merge after reset
      va = '{0, 1, 2, 3, 4, 5, 6, 7};
      vb = '{100, 101, 102, 103, 104, 105, 106, 107};
      ve = '{0, 1, 2, 3, 4, 5, 6, 7, 100, 101, 102, 103, 104, 105, 106, 107};
      run_test(16'h00FF, 1'b0, 1'b0);

`ifdef RUN_MERGE_ORDER_CHECK_EN
      // unsorted A: flag raised, still 16 beats
      va = '{1, 2, 9, 3, 4, 5, 6, 7};
      vb = '{10, 11, 12, 13, 14, 15, 16, 17};
      ve = '{1, 2, 9, 3, 4, 5, 6, 7, 10, 11, 12, 13, 14, 15, 16, 17};
      run_test(16'h00FF, 1'b0, 1'b1);
      chk("sort_err_sticky", sort_err, 1);
`endif

      // sorted runs clear any previous order flag
      va = '{1, 3, 5, 7, 9, 11, 13, 15};
      vb = '{2, 4, 6, 8, 10, 12, 14, 16};
      ve = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
      run_test(16'h5555, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/run_merge8.md
Name: run_merge8

Overview:
- Downstream neighbour of the 8-entry insertion sorter.
- Captures two sorted runs of RUN_LEN words, A and B, each taken from one sorter pass.
- Merges them into one ascending stream of 2*RUN_LEN words.
- Emits one word per accepted beat over a valid/ready handshake. This is the merge step of the TimSort flow.

Parameters:
- WIDTH, 32, data word width in bits
- RUN_LEN, 8, words per input run; must be >= 2

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  capture run_a/run_b and begin a merge; honoured only in IDLE
- run_a  input  WIDTH*RUN_LEN  sorted run A; word k at bits [k*WIDTH +: WIDTH], word 0 smallest
- run_b  input  WIDTH*RUN_LEN  sorted run B; same packing as run_a
- busy  output  1  high from the capture cycle until done
- out_valid  output  1  out_data holds a merged word
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- out_data  output  WIDTH  current merged word
- out_last  output  1  high with the final (2*RUN_LEN-th) word
- done  output  1  one-cycle pulse after the final beat
- sort_err  output  1  input run not ascending (see Optional Feature)

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, out_valid, out_last, done and sort_err all 0; pointers ia, ib and beat count cleared. Run storage is not reset.
- States: IDLE, MERGE, DONE.
- IDLE:
  - On start=1, latch run_a into mem_a and run_b into mem_b.
  - Clear ia, ib and cnt; busy<=1; go to MERGE.
  - First out_valid is seen the cycle after start (latency 1).
- MERGE:
  - out_valid=1 throughout.
  - Select A when ib==RUN_LEN, or when ia<RUN_LEN and mem_a[ia] <= mem_b[ib]. Otherwise select B.
  - The compare is unsigned. Ties take A, so the merge is stable.
  - out_data is the selected word, decoded from registered state only. out_data and out_last are stable while out_valid && !out_ready.
  - On each beat (out_valid && out_ready), increment the selected pointer and cnt.
  - out_last = (cnt == 2*RUN_LEN-1).
  - The beat with out_last=1 moves to DONE.
- DONE: done=1 for exactly one cycle; busy<=0; out_valid=0; return to IDLE.
- Backpressure: out_ready may drop on any cycle. No word is lost or duplicated. The pointers hold while stalled.
- Widths: ia and ib are $clog2(RUN_LEN)+1 bits, so they can reach RUN_LEN. cnt is $clog2(2*RUN_LEN)+1 bits.
- start is ignored while not in IDLE, including the DONE cycle. start in the cycle after DONE is accepted.
- Exhausted run: once one run is empty, the remaining words of the other run stream out in order with no extra cycles.
- Throughput: with out_ready held high, 2*RUN_LEN consecutive beats, and done on the following cycle.
- rst_n asserted mid-merge: outputs drop to their reset values immediately (asynchronously). The merge is abandoned and not resumed.
- Unsorted input runs (without the check) give an undefined output order, but the block still emits exactly 2*RUN_LEN beats.

Optional Feature:
- Macro: RUN_MERGE_ORDER_CHECK_EN.
- Defined:
  - At capture, check both runs for non-decreasing order (word k <= word k+1, unsigned).
  - If either run violates it, sort_err<=1 in the first MERGE cycle.
  - sort_err is sticky until the next accepted start or until reset.
  - The merge proceeds normally regardless.
- Undefined: sort_err is tied to 0 and no check logic is built.

Test Plan:
- Interleaved runs, ready held high:
  - Stimulus: A={1,3,5,7,9,11,13,15}, B={2,4,6,8,10,12,14,16}, start pulse.
  - Required: out_data 1..16 on 16 consecutive cycles starting the cycle after start; out_last with 16; done pulse the next cycle.
- Disjoint runs:
  - Stimulus: A={100..107}, B={0..7}.
  - Required: 0..7 then 100..107; ia stays 0 for the first 8 beats.
- Ties and stability:
  - Stimulus: A all 5 (words tagged via a debug probe), B all 5.
  - Required: 16 beats of 5, all eight A words before any B word. Also A={0,0xFFFFFFFF,...} checks the unsigned compare: 0xFFFFFFFF is emitted last.
- Random backpressure:
  - Stimulus: out_ready toggles pseudo-randomly, including long stalls.
  - Required: the sequence equals the software merge; out_data is constant across every stall; start pulses mid-merge are ignored.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 after beat 5.
  - Required: out_valid, busy and done are 0 within the same cycle. After release, a new start with fresh runs merges correctly from word 0.
- With RUN_MERGE_ORDER_CHECK_EN defined:
  - Stimulus: A={1,2,9,3,4,5,6,7}.
  - Required: sort_err=1 from the first MERGE cycle, still 16 beats, and sort_err cleared by the next start with sorted runs.
